// File: rtl/ram1k_arbiter.sv
// Round-robin front end for a 1K x 8 single-port RAM: serialises single-word
// read/write requests from two requesters and owns the bidirectional data bus.
module ram1k_arbiter #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [9:0] addr0,
   input  logic [9:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata,
   output logic       busy,
   output logic [9:0] ram_addr,
   output logic       ram_cs,
   output logic       ram_en,
   output logic       ram_rws,
   inout  wire  [7:0] ram_data
);

   localparam logic [1:0] WaitInit = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StAck
   } state_e;

   state_e     state_q, state_d;
   logic       last_q, last_d;
   logic       cmd_we_q, cmd_we_d;
   logic [9:0] cmd_addr_q, cmd_addr_d;
   logic [7:0] cmd_wdata_q, cmd_wdata_d;
   logic [1:0] wait_q, wait_d;
   logic [7:0] rdata_q, rdata_d;
   logic       win;
   logic       drive_bus;

   // last_q doubles as the grant of the transaction in flight.
   assign win = (req0 && req1) ? ~last_q : req1;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      wait_d      = wait_q;
      rdata_d     = rdata_q;
      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               last_d      = win;
               cmd_we_d    = win ? we1 : we0;
               cmd_addr_d  = win ? addr1 : addr0;
               cmd_wdata_d = win ? wdata1 : wdata0;
               wait_d      = WaitInit;
               state_d     = StAccess;
            end
         end
         StAccess: begin
            if (cmd_we_q || (wait_q == 2'd0)) begin
               if (!cmd_we_q) begin
                  rdata_d = ram_data;
               end
               state_d = StAck;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= 10'h000;
         cmd_wdata_q <= 8'h00;
         wait_q      <= 2'd0;
         rdata_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         wait_q      <= wait_d;
         rdata_q     <= rdata_d;
      end
   end

   // The bus is only ever driven while ram_rws is high, so the RAM and this
   // block can never contend.
   assign drive_bus = (state_q == StAccess) && cmd_we_q;
   assign ram_data  = drive_bus ? cmd_wdata_q : 8'hzz;

   assign ram_cs   = (state_q == StAccess);
   assign ram_en   = (state_q == StAccess);
   assign ram_rws  = drive_bus;
   assign ram_addr = cmd_addr_q;
   assign busy     = (state_q != StIdle);
   assign ack0     = (state_q == StAck) && !last_q;
   assign ack1     = (state_q == StAck) && last_q;
   assign rdata    = rdata_q;

endmodule

// File: doc/ram1k_arbiter.md
# ram1k_arbiter

Two-port round-robin access controller for the 1K x 8 single-port RAM (10-bit address, 8-bit bidirectional data, CS/EN/RWS controls). Two independent requesters issue single-word read or write transactions over a req/ack handshake. The block serialises them onto the RAM pins, owns the tristate data bus, and returns read data. It sits directly in front of the RAM instance; nothing else drives the RAM pins.

## Interface
- `RD_LAT`, default 1: read latency, in cycles, from the RAM address/control presented to read data valid on the bus; legal range 1..4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1 each: request from requester 0 or 1; held high until the matching ack.
- `we0`, `we1` input 1 each: 1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1` input 10 each: word address; stable while req is high.
- `wdata0`, `wdata1` input 8 each: write data; stable while req is high.
- `ack0`, `ack1` output 1 each: one-cycle completion pulse for each requester.
- `rdata` output 8: read data, shared by both requesters; valid in the ack cycle of a read.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `ram_addr` output 10: drives RAM `IN_DEC`.
- `ram_cs`, `ram_en` output 1 each: RAM chip select and enable.
- `ram_rws` output 1: 1 = write, 0 = read.
- `ram_data` inout 8: RAM `INOUT` bus.

## Operation
- The FSM has three states: IDLE, ACCESS and ACK.
- IDLE:
  - Arbitration is combinational on `req0`/`req1`.
  - On an edge where at least one request is high, the controller registers the winner's we, addr and wdata into a command register. It records the winner in `last` and moves to ACCESS.
- Round-robin rule:
  - If both requests are high, the requester that is not `last` wins.
  - A lone request always wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- ACCESS, write:
  - Lasts 1 cycle with `ram_cs`=1, `ram_en`=1, `ram_rws`=1, `ram_addr` from the command register, and `ram_data` driven with wdata.
  - The RAM writes on the edge that ends the cycle.
- ACCESS, read:
  - Lasts `RD_LAT` cycles with `ram_cs`=1, `ram_en`=1, `ram_rws`=0 and `ram_data` released to Z.
  - On the edge that ends the last ACCESS cycle, `ram_data` is captured into the `rdata` register.
  - A wait counter counts these cycles. It is 2 bits wide and loads `RD_LAT`-1 on entry.
- ACK:
  - Lasts 1 cycle; ack goes high for the granted requester only, and the FSM then returns to IDLE.
  - `rdata` holds its value until the next read capture; writes do not modify it.
- Requester rule:
  - Deassert req on the cycle after sampling ack high.
  - A req still high in IDLE after the ack is a new transaction.
- Bus ownership:
  - `ram_data` is driven only during write ACCESS; it is Z in every other state and during reset.
  - `ram_rws` is 0 whenever the bus is not driven, so the RAM and the controller never drive simultaneously.
- Outside ACCESS, `ram_cs` and `ram_en` are 0 and `ram_addr` holds its last value.
- Addresses pass through unmodified; 0x3FF is valid. The block does no address arithmetic.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - FSM = IDLE, `last` = 1, all acks = 0, `busy` = 0.
  - `ram_cs` = `ram_en` = `ram_rws` = 0, `ram_addr` = 0, `rdata` = 0x00, `ram_data` = Z.
- Write latency: req sampled at edge E0; ACCESS occupies cycle E0–E1; ack is high in cycle E1–E2. Total 3 cycles per write, including the IDLE cycle.
- Read latency: ack is high `RD_LAT`+1 cycles after the sampling edge. Total `RD_LAT`+2 cycles per read.
- Under saturated requests from both sides, grants alternate strictly: 0, 1, 0, 1…
- A request that arrives while `busy` is high waits; it is evaluated at the next IDLE.
- Reset asserted mid-ACCESS or mid-ACK:
  - Outputs go to reset values immediately and the bus is released.
  - The transaction is dropped, no ack is issued, and a write in progress may or may not have reached the RAM.
- A req that drops before its ack is a protocol violation. The latched command still completes and is acked.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs at the reset values above, `ram_data`=Z; after release, `busy`=0.
- Single write then read on port 0 (`RD_LAT`=1):
  - Write addr 0x001, data 0x10 → `ram_cs`/`ram_en`/`ram_rws`=1 for exactly one cycle with bus = 0x10; `ack0` 2 cycles after the sampling edge.
  - Read addr 0x001 → `rdata`=0x10 in the `ack0` cycle; bus Z throughout.
- Tie after reset: `req0` (write 0x002 ← 0x20) and `req1` (read 0x002) raised in the same cycle → port 0 is served first; `ack1` then returns `rdata`=0x20.
- Saturation: both reqs held for 6 transactions → ack order 0, 1, 0, 1, 0, 1; no cycle has `ram_rws`=0 with the bus driven.
- Reset mid-read: with `RD_LAT`=3, assert `rst_n`=0 in the second ACCESS cycle → no ack, outputs at reset values; after release, a read of 0x3FF previously written with 0x35 returns 0x35.
- `RD_LAT` sweep 1..4: read ack arrives exactly `RD_LAT`+1 cycles after the sampling edge, with correct data.
